// File: rtl/fag_step_ctrl.sv
// fag_step_ctrl: step-command generator for the F/A rocking register block.
// Settle timer + debounced cry sensor -> single-cycle Fhoog/Flaag/Alaag pulses.
//
// Ports:
//   clk, reset_n         rising-edge clock, async active-low reset
//   enable               run request (level); low returns to IDLE
//   cry                  sensor level, synchronous to clk
//   F, A                 current register-block settings (3 bits each)
//   F0, AF0              F==0 and (F==0 && A==0) flags
//   Fhoog, Flaag, Alaag  F+1 / F-1 / A-1 request pulses (registered)
//   rocking_done         high while in DONE
//   alarm                sticky: cry event seen in DONE
//
// Build option: FAG_STEP_CTRL_CRY_BOOST_EN enables Fhoog on cry events;
// without it a cry event only restarts the settle timer.

module fag_step_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int CRY_DEBOUNCE  = 4,
    parameter int F_MAX         = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       cry,
    input  logic [2:0] F,
    input  logic [2:0] A,
    input  logic       F0,
    input  logic       AF0,
    output logic       Fhoog,
    output logic       Flaag,
    output logic       Alaag,
    output logic       rocking_done,
    output logic       alarm
);

    localparam int TW = $clog2(SETTLE_CYCLES);
    localparam int DW = $clog2(CRY_DEBOUNCE + 1);

    localparam logic [TW-1:0] T_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] D_MAX  = DW'(CRY_DEBOUNCE);
    localparam logic [DW-1:0] D_LAST = DW'(CRY_DEBOUNCE - 1);
    localparam logic [2:0]    F_LIM  = 3'(F_MAX);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_STEP   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]    state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          pend, pend_n;
    logic [DW-1:0] cry_cnt;
    logic          cry_evt;
    logic          trig;
    logic          fh_n, fl_n, al_n, done_n, alarm_n;

    // A is only implied through AF0/F0; F is read only for the boost bound.
    logic unused_in;
    assign unused_in = ^{A, F, F_LIM};

    // Debounce: counter saturates at CRY_DEBOUNCE and clears only when
    // cry drops, so a held cry produces exactly one event pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cry_cnt <= '0;
            cry_evt <= 1'b0;
        end else if (!cry) begin
            cry_cnt <= '0;
            cry_evt <= 1'b0;
        end else if (cry_cnt != D_MAX) begin
            cry_cnt <= cry_cnt + DW'(1);
            cry_evt <= (cry_cnt == D_LAST);
        end else begin
            cry_evt <= 1'b0;
        end
    end

    assign trig = cry_evt | pend;

    always_comb begin
        state_n = state;
        timer_n = timer;
        pend_n  = pend;
        fh_n    = 1'b0;
        fl_n    = 1'b0;
        al_n    = 1'b0;
        done_n  = 1'b0;
        alarm_n = alarm;
        if (!enable) begin
            state_n = S_IDLE;
            pend_n  = 1'b0;
            alarm_n = 1'b0;
        end else begin
            unique case (1'b1)
                (state == S_IDLE): begin
                    state_n = S_SETTLE;
                    timer_n = T_LOAD;
                    alarm_n = 1'b0;
                end
                (state == S_SETTLE): begin
                    if (trig) begin
                        // Cry wins over a timer expiry in the same cycle.
                        pend_n = 1'b0;
`ifdef FAG_STEP_CTRL_CRY_BOOST_EN
                        if (F < F_LIM) begin
                            state_n = S_STEP;
                            fh_n    = 1'b1;
                        end else begin
                            timer_n = T_LOAD;
                        end
`else
                        timer_n = T_LOAD;
`endif
                    end else if (timer == '0) begin
                        if (AF0) begin
                            state_n = S_DONE;
                            done_n  = 1'b1;
                        end else if (!F0) begin
                            state_n = S_STEP;
                            fl_n    = 1'b1;
                        end else begin
                            state_n = S_STEP;
                            al_n    = 1'b1;
                        end
                    end else begin
                        timer_n = timer - TW'(1);
                    end
                end
                (state == S_STEP): begin
                    state_n = S_WAIT;
                    if (cry_evt) pend_n = 1'b1;
                end
                (state == S_WAIT): begin
                    state_n = S_SETTLE;
                    timer_n = T_LOAD;
                    if (cry_evt) pend_n = 1'b1;
                end
                (state == S_DONE): begin
                    done_n = 1'b1;
                    if (cry_evt) alarm_n = 1'b1;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            timer        <= '0;
            pend         <= 1'b0;
            Fhoog        <= 1'b0;
            Flaag        <= 1'b0;
            Alaag        <= 1'b0;
            rocking_done <= 1'b0;
            alarm        <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            pend         <= pend_n;
            Fhoog        <= fh_n;
            Flaag        <= fl_n;
            Alaag        <= al_n;
            rocking_done <= done_n;
            alarm        <= alarm_n;
        end
    end

endmodule

// File: tb/tb_fag_step_ctrl.sv
// tb_fag_step_ctrl: randomized scenarios for fag_step_ctrl against a
// timing model of pulse schedules plus a behavioural F/A register block.

module tb_fag_step_ctrl;

    localparam int S  = 4;
    localparam int D  = 2;
    localparam int FM = 5;
`ifdef FAG_STEP_CTRL_CRY_BOOST_EN
    localparam bit BOOST = 1'b1;
`else
    localparam bit BOOST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       cry;
    logic [2:0] mf;
    logic [2:0] ma;
    logic       f0;
    logic       af0;
    logic       fhoog, flaag, alaag, rocking_done, alarm;

    logic       ld;
    logic [2:0] ld_f, ld_a;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    int       lt[$];
    logic [2:0] lv[$];
    int       dq[$];
    logic     done_prev = 1'b0;

    int         et[$];
    logic [2:0] ev[$];

    fag_step_ctrl #(
        .SETTLE_CYCLES(S),
        .CRY_DEBOUNCE (D),
        .F_MAX        (FM)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .cry         (cry),
        .F           (mf),
        .A           (ma),
        .F0          (f0),
        .AF0         (af0),
        .Fhoog       (fhoog),
        .Flaag       (flaag),
        .Alaag       (alaag),
        .rocking_done(rocking_done),
        .alarm       (alarm)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register block the controller steps.
    always @(posedge clk) begin
        if (ld) begin
            mf <= ld_f;
            ma <= ld_a;
        end else if (fhoog) begin
            mf <= mf + 3'd1;
        end else if (flaag) begin
            mf <= mf - 3'd1;
        end else if (alaag) begin
            ma <= ma - 3'd1;
        end
    end

    assign f0  = (mf == 3'd0);
    assign af0 = (mf == 3'd0) && (ma == 3'd0);

    always @(negedge clk) begin
        if ({fhoog, flaag, alaag} != 3'b000) begin
            lt.push_back(cyc);
            lv.push_back({fhoog, flaag, alaag});
        end
        if (rocking_done && !done_prev) dq.push_back(cyc);
        done_prev = rocking_done;
    end

    function automatic int add_downs(input int start, input int nf,
                                     input int na);
        for (int i = 0; i < nf + na; i++) begin
            et.push_back(start + i * (S + 2));
            ev.push_back(i < nf ? 3'b010 : 3'b001);
        end
        return start + (nf + na) * (S + 2);
    endfunction

    task automatic wait_to(input int c);
        int n;
        n = 0;
        while (cyc < c && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (cyc < c) begin
            bad++;
            $display("FAIL wait_timeout got=%0d want=%0d", cyc, c);
        end
    endtask

    task automatic set_fa(input int f, input int a);
        @(negedge clk);
        ld   = 1'b1;
        ld_f = 3'(f);
        ld_a = 3'(a);
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic go(output int c0);
        @(negedge clk);
        enable = 1'b1;
        c0 = cyc;
    endtask

    task automatic stop();
        @(negedge clk);
        enable = 1'b0;
        cry = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic burst();
        cry = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cry = 1'b0;
    endtask

    task automatic test_reset();
        int b;
        reset_n = 1'b0;
        enable = 1'b0;
        cry = 1'b0;
        ld = 1'b0;
        ld_f = 3'd0;
        ld_a = 3'd0;
        repeat (3) @(negedge clk);
        total++;
        if ({fhoog, flaag, alaag, rocking_done, alarm} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outs got=%b want=00000",
                     {fhoog, flaag, alaag, rocking_done, alarm});
        end
        @(negedge clk);
        reset_n = 1'b1;
        b = lt.size();
        repeat (6) @(negedge clk);
        total++;
        if (lt.size() - b != 0 || rocking_done !== 1'b0) begin
            bad++;
            $display("FAIL idle_quiet got=%0d/%b want=0/0",
                     lt.size() - b, rocking_done);
        end
    endtask

    task automatic test_calm();
        int f, a, b, db, c0, ed, dg;
        for (int it = 0; it < 3; it++) begin
            f = (it == 0) ? 5 : int'($urandom_range(0, FM));
            a = (it == 0) ? 5 : int'($urandom_range(0, 5));
            set_fa(f, a);
            b = lt.size();
            db = dq.size();
            et.delete();
            ev.delete();
            go(c0);
            ed = add_downs(c0 + 1 + S, f, a);
            wait_to(ed + 3 * (S + 2));
            total++;
            if (lt.size() - b != et.size()) begin
                bad++;
                $display("FAIL calm_count it=%0d got=%0d want=%0d",
                         it, lt.size() - b, et.size());
            end
            for (int i = 0; i < et.size(); i++) begin
                total++;
                if (b + i >= lt.size()) begin
                    bad++;
                    $display("FAIL calm_pulse%0d got=none want=%0d/%b",
                             i, et[i], ev[i]);
                end else if (lt[b+i] !== et[i] || lv[b+i] !== ev[i]) begin
                    bad++;
                    $display("FAIL calm_pulse%0d got=%0d/%b want=%0d/%b",
                             i, lt[b+i], lv[b+i], et[i], ev[i]);
                end
            end
            total++;
            dg = (dq.size() > db) ? dq[db] : -1;
            if (dg !== ed || dq.size() - db != 1) begin
                bad++;
                $display("FAIL calm_done got=%0d want=%0d", dg, ed);
            end
            stop();
        end
    endtask

    task automatic test_cry();
        int f, a, b, db, c0, ed, dg, s;
        for (int it = 0; it < 5; it++) begin
            f = (it == 0) ? 2 : int'($urandom_range(1, FM));
            a = int'($urandom_range(0, 2));
            set_fa(f, a);
            b = lt.size();
            db = dq.size();
            et.delete();
            ev.delete();
            go(c0);
            if (it == 1) s = c0 + S + 1;
            else s = c0 + int'($urandom_range(3, S + 1));
            wait_to(s - 3);
            burst();
            if (BOOST && f < FM) begin
                et.push_back(s);
                ev.push_back(3'b100);
                ed = add_downs(s + 2 + S, f + 1, a);
            end else begin
                ed = add_downs(s + S, f, a);
            end
            wait_to(ed + S);
            total++;
            if (lt.size() - b != et.size()) begin
                bad++;
                $display("FAIL cry_count it=%0d got=%0d want=%0d",
                         it, lt.size() - b, et.size());
            end
            for (int i = 0; i < et.size(); i++) begin
                total++;
                if (b + i >= lt.size()) begin
                    bad++;
                    $display("FAIL cry_pulse%0d got=none want=%0d/%b",
                             i, et[i], ev[i]);
                end else if (lt[b+i] !== et[i] || lv[b+i] !== ev[i]) begin
                    bad++;
                    $display("FAIL cry_pulse%0d got=%0d/%b want=%0d/%b",
                             i, lt[b+i], lv[b+i], et[i], ev[i]);
                end
            end
            total++;
            dg = (dq.size() > db) ? dq[db] : -1;
            if (dg !== ed) begin
                bad++;
                $display("FAIL cry_done got=%0d want=%0d", dg, ed);
            end
            stop();
        end
    endtask

    task automatic test_upper_bound();
        int a, b, c0, ed, s, m;
        for (int it = 0; it < 2; it++) begin
            a = int'($urandom_range(0, 2));
            set_fa(FM, a);
            b = lt.size();
            et.delete();
            ev.delete();
            go(c0);
            m = int'($urandom_range(2, 4));
            s = c0 + int'($urandom_range(3, S + 1));
            for (int j = 0; j < m; j++) begin
                wait_to(s - 3);
                burst();
                if (j < m - 1) s = s + int'($urandom_range(3, S));
            end
            ed = add_downs(s + S, FM, a);
            wait_to(ed + S);
            total++;
            if (lt.size() - b != et.size()) begin
                bad++;
                $display("FAIL bound_count it=%0d got=%0d want=%0d",
                         it, lt.size() - b, et.size());
            end
            for (int i = 0; i < et.size(); i++) begin
                total++;
                if (b + i >= lt.size()) begin
                    bad++;
                    $display("FAIL bound_pulse%0d got=none want=%0d/%b",
                             i, et[i], ev[i]);
                end else if (lt[b+i] !== et[i] || lv[b+i] !== ev[i]) begin
                    bad++;
                    $display("FAIL bound_pulse%0d got=%0d/%b want=%0d/%b",
                             i, lt[b+i], lv[b+i], et[i], ev[i]);
                end
            end
            stop();
        end
    endtask

    task automatic test_pending();
        int f, a, b, c0, t, k;
        for (int it = 0; it < 3; it++) begin
            f = int'($urandom_range(1, FM));
            a = int'($urandom_range(0, 2));
            set_fa(f, a);
            b = lt.size();
            et.delete();
            ev.delete();
            go(c0);
            t = c0 + 1 + S;
            k = t - 1 + int'($urandom_range(0, 1));
            wait_to(k - 1);
            burst();
            et.push_back(t);
            ev.push_back(3'b010);
            if (BOOST) begin
                et.push_back(t + 3);
                ev.push_back(3'b100);
                void'(add_downs(t + 5 + S, f, a));
            end else begin
                void'(add_downs(t + 3 + S, f - 1, a));
            end
            wait_to(et[et.size()-1] + 2 * (S + 2));
            total++;
            if (lt.size() - b != et.size()) begin
                bad++;
                $display("FAIL pend_count it=%0d got=%0d want=%0d",
                         it, lt.size() - b, et.size());
            end
            for (int i = 0; i < et.size(); i++) begin
                total++;
                if (b + i >= lt.size()) begin
                    bad++;
                    $display("FAIL pend_pulse%0d got=none want=%0d/%b",
                             i, et[i], ev[i]);
                end else if (lt[b+i] !== et[i] || lv[b+i] !== ev[i]) begin
                    bad++;
                    $display("FAIL pend_pulse%0d got=%0d/%b want=%0d/%b",
                             i, lt[b+i], lv[b+i], et[i], ev[i]);
                end
            end
            stop();
        end
    endtask

    task automatic test_done_alarm();
        int f, a, b, c0, ed, j;
        f = int'($urandom_range(0, 1));
        a = int'($urandom_range(0, 1));
        set_fa(f, a);
        b = lt.size();
        et.delete();
        ev.delete();
        go(c0);
        ed = add_downs(c0 + 1 + S, f, a);
        wait_to(ed + 1);
        total++;
        if (rocking_done !== 1'b1 || alarm !== 1'b0) begin
            bad++;
            $display("FAIL done_reach got=%b%b want=10", rocking_done, alarm);
        end
        j = cyc;
        burst();
        total++;
        if (alarm !== 1'b0) begin
            bad++;
            $display("FAIL alarm_early got=%b want=0", alarm);
        end
        wait_to(j + 3);
        total++;
        if (alarm !== 1'b1) begin
            bad++;
            $display("FAIL alarm_set got=%b want=1", alarm);
        end
        wait_to(j + 8);
        total++;
        if (alarm !== 1'b1 || rocking_done !== 1'b1 ||
            lt.size() - b != f + a) begin
            bad++;
            $display("FAIL alarm_sticky got=%b%b/%0d want=11/%0d",
                     alarm, rocking_done, lt.size() - b, f + a);
        end
        enable = 1'b0;
        @(negedge clk);
        total++;
        if (rocking_done !== 1'b0 || alarm !== 1'b0) begin
            bad++;
            $display("FAIL done_exit got=%b%b want=00", rocking_done, alarm);
        end
        burst();
        repeat (3) @(negedge clk);
        total++;
        if (alarm !== 1'b0) begin
            bad++;
            $display("FAIL alarm_idle got=%b want=0", alarm);
        end
        stop();
    endtask

    task automatic test_enable_drop();
        int b, db, c0, r, tt;
        set_fa(FM, 3);
        b = lt.size();
        db = dq.size();
        et.delete();
        ev.delete();
        go(c0);
        r = c0 + int'($urandom_range(2, 40));
        wait_to(r);
        enable = 1'b0;
        for (int i = 0; i < FM + 3; i++) begin
            tt = c0 + 1 + S + i * (S + 2);
            if (tt <= r) begin
                et.push_back(tt);
                ev.push_back(i < FM ? 3'b010 : 3'b001);
            end
        end
        wait_to(r + 20);
        total++;
        if (lt.size() - b != et.size() || dq.size() != db) begin
            bad++;
            $display("FAIL drop_count got=%0d/%0d want=%0d/0",
                     lt.size() - b, dq.size() - db, et.size());
        end
        for (int i = 0; i < et.size(); i++) begin
            total++;
            if (b + i >= lt.size()) begin
                bad++;
                $display("FAIL drop_pulse%0d got=none want=%0d", i, et[i]);
            end else if (lt[b+i] !== et[i] || lv[b+i] !== ev[i]) begin
                bad++;
                $display("FAIL drop_pulse%0d got=%0d/%b want=%0d/%b",
                         i, lt[b+i], lv[b+i], et[i], ev[i]);
            end
        end
        stop();
    endtask

    task automatic test_async_reset();
        int f, a, b, db, c0, c, ed, dg;
        f = int'($urandom_range(1, FM));
        a = int'($urandom_range(0, 2));
        set_fa(f, a);
        go(c0);
        wait_to(c0 + 1 + S);
        total++;
        if (flaag !== 1'b1) begin
            bad++;
            $display("FAIL ar_pulse got=%b want=1", flaag);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({fhoog, flaag, alaag, rocking_done, alarm} !== 5'b0) begin
            bad++;
            $display("FAIL ar_clear got=%b want=00000",
                     {fhoog, flaag, alaag, rocking_done, alarm});
        end
        @(negedge clk);
        @(negedge clk);
        b = lt.size();
        db = dq.size();
        et.delete();
        ev.delete();
        c = cyc;
        reset_n = 1'b1;
        ed = add_downs(c + 1 + S, f, a);
        wait_to(ed + S);
        total++;
        if (lt.size() - b != et.size()) begin
            bad++;
            $display("FAIL ar_count got=%0d want=%0d",
                     lt.size() - b, et.size());
        end
        for (int i = 0; i < et.size(); i++) begin
            total++;
            if (b + i >= lt.size()) begin
                bad++;
                $display("FAIL ar_pulse%0d got=none want=%0d", i, et[i]);
            end else if (lt[b+i] !== et[i] || lv[b+i] !== ev[i]) begin
                bad++;
                $display("FAIL ar_pulse%0d got=%0d/%b want=%0d/%b",
                         i, lt[b+i], lv[b+i], et[i], ev[i]);
            end
        end
        total++;
        dg = (dq.size() > db) ? dq[db] : -1;
        if (dg !== ed) begin
            bad++;
            $display("FAIL ar_done got=%0d want=%0d", dg, ed);
        end
        stop();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_calm();
        test_cry();
        test_upper_bound();
        test_pending();
        test_done_alarm();
        test_enable_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
